multicycle_control: RTL and testbench

//  Multi-cycle sequencer for the LEGv8 datapath. It decodes the same 11-bit opcode set as the

---
 rtl/legv8_ctrl_pkg.sv | 49 ++++
 rtl/multicycle_decode.sv | 31 +++
 rtl/multicycle_control.sv | 140 ++++++++++++++
 tb/tb_multicycle_control.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// Shared LEGv8 control constants: opcode match patterns, sequencer state codes,
// instruction classes and ALU/sign-extend control encodings.
package legv8_ctrl_pkg;

    // casez patterns; '?' bits are don't-care within the 11-bit opcode field
    localparam logic [10:0] OPCODE_LDUR   = 11'b11111000010;
    localparam logic [10:0] OPCODE_STUR   = 11'b11111000000;
    localparam logic [10:0] OPCODE_ADDREG = 11'b10001011000;
    localparam logic [10:0] OPCODE_ADDIMM = 11'b1001000100?;
    localparam logic [10:0] OPCODE_SUBREG = 11'b11001011000;
    localparam logic [10:0] OPCODE_SUBIMM = 11'b1101000100?;
    localparam logic [10:0] OPCODE_ANDREG = 11'b10001010000;
    localparam logic [10:0] OPCODE_ORRREG = 11'b10101010000;
    localparam logic [10:0] OPCODE_CBZ    = 11'b10110100???;
    localparam logic [10:0] OPCODE_B      = 11'b000101?????;
    localparam logic [10:0] OPCODE_MOVZ   = 11'b110100101??;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    localparam logic [3:0] CLASS_NONE   = 4'd0;
    localparam logic [3:0] CLASS_LDUR   = 4'd1;
    localparam logic [3:0] CLASS_STUR   = 4'd2;
    localparam logic [3:0] CLASS_ADDREG = 4'd3;
    localparam logic [3:0] CLASS_ADDIMM = 4'd4;
    localparam logic [3:0] CLASS_SUBREG = 4'd5;
    localparam logic [3:0] CLASS_SUBIMM = 4'd6;
    localparam logic [3:0] CLASS_ANDREG = 4'd7;
    localparam logic [3:0] CLASS_ORRREG = 4'd8;
    localparam logic [3:0] CLASS_CBZ    = 4'd9;
    localparam logic [3:0] CLASS_B      = 4'd10;
    localparam logic [3:0] CLASS_MOVZ   = 4'd11;

    localparam logic [3:0] ALUOP_AND   = 4'b0000;
    localparam logic [3:0] ALUOP_ORR   = 4'b0001;
    localparam logic [3:0] ALUOP_ADD   = 4'b0010;
    localparam logic [3:0] ALUOP_SUB   = 4'b0110;
    localparam logic [3:0] ALUOP_PASSB = 4'b0111;

    localparam logic [2:0] SIGNOP_I  = 3'b000;
    localparam logic [2:0] SIGNOP_D  = 3'b001;
    localparam logic [2:0] SIGNOP_B  = 3'b010;
    localparam logic [2:0] SIGNOP_CB = 3'b011;

endpackage

// File: rtl/multicycle_decode.sv
// Combinational opcode classifier for the multi-cycle sequencer.
// Unmatched opcodes are flagged illegal; there is no fallback class.
module multicycle_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output logic [3:0]  op_class,
    output logic        illegal
);

    // first matching arm wins, giving the fixed classification priority
    always_comb begin
        op_class = CLASS_NONE;
        illegal  = 1'b0;
        casez (opcode)
            OPCODE_LDUR:   op_class = CLASS_LDUR;
            OPCODE_STUR:   op_class = CLASS_STUR;
            OPCODE_ADDREG: op_class = CLASS_ADDREG;
            OPCODE_ADDIMM: op_class = CLASS_ADDIMM;
            OPCODE_SUBREG: op_class = CLASS_SUBREG;
            OPCODE_SUBIMM: op_class = CLASS_SUBIMM;
            OPCODE_ANDREG: op_class = CLASS_ANDREG;
            OPCODE_ORRREG: op_class = CLASS_ORRREG;
            OPCODE_CBZ:    op_class = CLASS_CBZ;
            OPCODE_B:      op_class = CLASS_B;
            OPCODE_MOVZ:   op_class = CLASS_MOVZ;
            default:       illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with a timed
// handshake to variable-latency data memory and a sticky error state.
module multicycle_control
    import legv8_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TO = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        irwrite,
    output logic        pcwrite,
    output logic        pcsrc,
    output logic        reg2loc,
    output logic        alusrc,
    output logic        mem2reg,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic [3:0]  aluop,
    output logic [2:0]  signop,
    output logic [2:0]  state,
    output logic        error
);

    logic [2:0] cur_state;
    logic [3:0] op_class;
    logic [2:0] movz_signop;
    logic [3:0] wait_cnt;
    logic [3:0] dec_class;
    logic       dec_illegal;

    multicycle_decode u_decode (
        .opcode   (opcode),
        .op_class (dec_class),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cur_state   <= ST_FETCH;
            op_class    <= CLASS_NONE;
            movz_signop <= '0;
            wait_cnt    <= '0;
        end else begin
            case (cur_state)
                ST_FETCH:  cur_state <= ST_DECODE;
                ST_DECODE: begin
                    op_class    <= dec_class;
                    movz_signop <= (dec_class == CLASS_MOVZ) ? opcode[2:0] : 3'b000;
                    cur_state   <= dec_illegal ? ST_ERR : ST_EXEC;
                end
                ST_EXEC: begin
                    wait_cnt <= '0;
                    case (op_class)
                        CLASS_B, CLASS_CBZ:      cur_state <= ST_FETCH;
                        CLASS_LDUR, CLASS_STUR:  cur_state <= ST_MEM;
                        CLASS_NONE:              cur_state <= ST_ERR;
                        default:                 cur_state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        wait_cnt  <= '0;
                        cur_state <= (op_class == CLASS_LDUR) ? ST_WB : ST_FETCH;
                    end else if (wait_cnt == 4'(MEM_TO)) begin
                        cur_state <= ST_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_WB:   cur_state <= ST_FETCH;
                default: cur_state <= ST_ERR;
            endcase
        end
    end

    always_comb begin
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        pcsrc    = 1'b0;
        reg2loc  = 1'b0;
        alusrc   = 1'b0;
        mem2reg  = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        aluop    = ALUOP_AND;
        signop   = SIGNOP_I;
        error    = 1'b0;

        // ALU/extend controls stay valid through MEM for the address computation
        if (cur_state == ST_EXEC || cur_state == ST_MEM) begin
            case (op_class)
                CLASS_LDUR:   begin alusrc = 1'b1; aluop = ALUOP_ADD; signop = SIGNOP_D; end
                CLASS_STUR:   begin reg2loc = 1'b1; alusrc = 1'b1; aluop = ALUOP_ADD; signop = SIGNOP_D; end
                CLASS_ADDREG: aluop = ALUOP_ADD;
                CLASS_ADDIMM: begin alusrc = 1'b1; aluop = ALUOP_ADD; end
                CLASS_SUBREG: aluop = ALUOP_SUB;
                CLASS_SUBIMM: begin alusrc = 1'b1; aluop = ALUOP_SUB; end
                CLASS_ANDREG: aluop = ALUOP_AND;
                CLASS_ORRREG: aluop = ALUOP_ORR;
                CLASS_CBZ:    begin reg2loc = 1'b1; aluop = ALUOP_PASSB; signop = SIGNOP_CB; end
                CLASS_B:      signop = SIGNOP_B;
                CLASS_MOVZ:   begin alusrc = 1'b1; aluop = ALUOP_PASSB; signop = movz_signop; end
                default:      ;
            endcase
        end

        case (cur_state)
            ST_FETCH: irwrite = 1'b1;
            ST_EXEC: begin
                if (op_class == CLASS_B) begin
                    pcwrite = 1'b1;
                    pcsrc   = 1'b1;
                end else if (op_class == CLASS_CBZ) begin
                    pcwrite = 1'b1;
                    pcsrc   = zero;
                end
            end
            ST_MEM: begin
                memread  = (op_class == CLASS_LDUR);
                memwrite = (op_class == CLASS_STUR);
                pcwrite  = (op_class == CLASS_STUR) && mem_ready;
            end
            ST_WB: begin
                regwrite = 1'b1;
                mem2reg  = (op_class == CLASS_LDUR);
                pcwrite  = 1'b1;
            end
            ST_ERR:  error = 1'b1;
            default: ;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-scenario tasks with hand-computed
// expectations for state sequence, strobes, memory handshake and error paths.
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        irwrite, pcwrite, pcsrc, reg2loc, alusrc, mem2reg, regwrite, memread, memwrite;
    logic [3:0]  aluop;
    logic [2:0]  signop;
    logic [2:0]  state;
    logic        error;

    int unsigned passed = 0;
    int unsigned total = 0;

    multicycle_control #(.MEM_TO(15)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc), .reg2loc(reg2loc),
        .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread),
        .memwrite(memwrite), .aluop(aluop), .signop(signop), .state(state), .error(error)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        step();
        Reset = 1'b1; zero = 1'b0; mem_ready = 1'b0;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({state, irwrite, error} !== {3'd0, 1'b1, 1'b0})
            $display("FAIL reset_state: state=%0d irwrite=%b error=%b want 0/1/0", state, irwrite, error);
        else passed++;
        total++;
        if ({pcwrite, regwrite, memread, memwrite} !== 4'b0000)
            $display("FAIL reset_strobes: got %b want 0000", {pcwrite, regwrite, memread, memwrite});
        else passed++;
    endtask

    task automatic test_add();
        do_reset();
        opcode = 11'b10001011000;
        step(); #1;
        total++;
        if ({state, pcwrite} !== {3'd1, 1'b0})
            $display("FAIL add_decode: state=%0d pcwrite=%b want 1/0", state, pcwrite);
        else passed++;
        step(); #1;
        total++;
        if ({state, aluop, alusrc, regwrite, pcwrite} !== {3'd2, 4'b0010, 1'b0, 1'b0, 1'b0})
            $display("FAIL add_exec: state=%0d aluop=%b alusrc=%b regwrite=%b pcwrite=%b want 2/0010/0/0/0",
                     state, aluop, alusrc, regwrite, pcwrite);
        else passed++;
        step(); #1;
        total++;
        if ({state, regwrite, pcwrite, pcsrc, mem2reg} !== {3'd4, 1'b1, 1'b1, 1'b0, 1'b0})
            $display("FAIL add_wb: state=%0d regwrite=%b pcwrite=%b pcsrc=%b mem2reg=%b want 4/1/1/0/0",
                     state, regwrite, pcwrite, pcsrc, mem2reg);
        else passed++;
        step(); #1;
        total++;
        if (state !== 3'd0) $display("FAIL add_retire: state=%0d want 0", state);
        else passed++;
    endtask

    task automatic test_ldur();
        do_reset();
        opcode = 11'b11111000010;
        step(); step(); #1;
        total++;
        if ({state, aluop, alusrc, signop} !== {3'd2, 4'b0010, 1'b1, 3'b001})
            $display("FAIL ldur_exec: state=%0d aluop=%b alusrc=%b signop=%b want 2/0010/1/001",
                     state, aluop, alusrc, signop);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            mem_ready = (i == 3);
            #1;
            total++;
            if ({state, memread, memwrite, pcwrite} !== {3'd3, 1'b1, 1'b0, 1'b0})
                $display("FAIL ldur_mem%0d: state=%0d memread=%b memwrite=%b pcwrite=%b want 3/1/0/0",
                         i, state, memread, memwrite, pcwrite);
            else passed++;
        end
        step();
        mem_ready = 1'b0;
        #1;
        total++;
        if ({state, mem2reg, regwrite, pcwrite, memread} !== {3'd4, 1'b1, 1'b1, 1'b1, 1'b0})
            $display("FAIL ldur_wb: state=%0d mem2reg=%b regwrite=%b pcwrite=%b memread=%b want 4/1/1/1/0",
                     state, mem2reg, regwrite, pcwrite, memread);
        else passed++;
        step(); #1;
        total++;
        if (state !== 3'd0) $display("FAIL ldur_retire_8cyc: state=%0d want 0", state);
        else passed++;
    endtask

    task automatic test_cbz();
        do_reset();
        opcode = 11'b10110100000;
        for (int k = 0; k < 2; k++) begin
            step(); step();
            zero = (k == 0);
            #1;
            total++;
            if ({state, pcwrite, pcsrc, reg2loc, aluop, signop} !==
                {3'd2, 1'b1, (k == 0), 1'b1, 4'b0111, 3'b011})
                $display("FAIL cbz_exec_z%0d: state=%0d pcwrite=%b pcsrc=%b reg2loc=%b aluop=%b signop=%b want 2/1/%0d/1/0111/011",
                         (k == 0), state, pcwrite, pcsrc, reg2loc, aluop, signop, (k == 0));
            else passed++;
            step();
            zero = ~zero;
            #1;
            total++;
            if ({state, pcwrite} !== {3'd0, 1'b0})
                $display("FAIL cbz_retire_z%0d: state=%0d pcwrite=%b want 0/0", (k == 0), state, pcwrite);
            else passed++;
        end
        zero = 1'b0;
    endtask

    task automatic test_movz();
        do_reset();
        opcode = 11'b11010010110;
        step(); step(); #1;
        total++;
        if ({state, signop, aluop, alusrc} !== {3'd2, 3'b110, 4'b0111, 1'b1})
            $display("FAIL movz_exec: state=%0d signop=%b aluop=%b alusrc=%b want 2/110/0111/1",
                     state, signop, aluop, alusrc);
        else passed++;
        step(); #1;
        total++;
        if ({state, regwrite, mem2reg, pcwrite} !== {3'd4, 1'b1, 1'b0, 1'b1})
            $display("FAIL movz_wb: state=%0d regwrite=%b mem2reg=%b pcwrite=%b want 4/1/0/1",
                     state, regwrite, mem2reg, pcwrite);
        else passed++;
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = 11'b11111111111;
        step(); step(); #1;
        total++;
        if ({state, error} !== {3'd5, 1'b1})
            $display("FAIL illegal_err: state=%0d error=%b want 5/1", state, error);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            step();
            mem_ready = i[0];
            zero = i[1];
            #1;
            total++;
            if ({state, error, irwrite, pcwrite, regwrite, memread, memwrite} !== {3'd5, 1'b1, 5'b00000})
                $display("FAIL illegal_hold%0d: state=%0d error=%b strobes=%b want 5/1/00000", i, state, error,
                         {irwrite, pcwrite, regwrite, memread, memwrite});
            else passed++;
        end
        mem_ready = 1'b0; zero = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        #1;
        total++;
        if ({state, error} !== {3'd0, 1'b0})
            $display("FAIL illegal_reset: state=%0d error=%b want 0/0", state, error);
        else passed++;
    endtask

    task automatic test_stur_timeout();
        do_reset();
        opcode = 11'b11111000000;
        step(); step(); #1;
        total++;
        if ({state, reg2loc, alusrc, signop} !== {3'd2, 1'b1, 1'b1, 3'b001})
            $display("FAIL stur_exec: state=%0d reg2loc=%b alusrc=%b signop=%b want 2/1/1/001",
                     state, reg2loc, alusrc, signop);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            step(); #1;
            total++;
            if ({state, memwrite, reg2loc, pcwrite} !== {3'd3, 1'b1, 1'b1, 1'b0})
                $display("FAIL stur_wait%0d: state=%0d memwrite=%b reg2loc=%b pcwrite=%b want 3/1/1/0",
                         i, state, memwrite, reg2loc, pcwrite);
            else passed++;
        end
        step(); #1;
        total++;
        if ({state, error, memwrite} !== {3'd5, 1'b1, 1'b0})
            $display("FAIL stur_timeout: state=%0d error=%b memwrite=%b want 5/1/0", state, error, memwrite);
        else passed++;
    endtask

    task automatic test_stur_late_ready();
        do_reset();
        opcode = 11'b11111000000;
        step(); step();
        for (int i = 0; i < 16; i++) begin
            step();
            mem_ready = (i == 15);
            #1;
        end
        total++;
        if ({state, memwrite, pcwrite, pcsrc} !== {3'd3, 1'b1, 1'b1, 1'b0})
            $display("FAIL stur_last_ready: state=%0d memwrite=%b pcwrite=%b pcsrc=%b want 3/1/1/0",
                     state, memwrite, pcwrite, pcsrc);
        else passed++;
        step();
        mem_ready = 1'b0;
        #1;
        total++;
        if ({state, error} !== {3'd0, 1'b0})
            $display("FAIL stur_last_retire: state=%0d error=%b want 0/0", state, error);
        else passed++;
    endtask

    task automatic test_stur_reset();
        do_reset();
        opcode = 11'b11111000000;
        step(); step(); step(); step(); #1;
        total++;
        if ({state, memwrite} !== {3'd3, 1'b1})
            $display("FAIL stur_mem2: state=%0d memwrite=%b want 3/1", state, memwrite);
        else passed++;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        #1;
        total++;
        if ({state, memwrite, irwrite} !== {3'd0, 1'b0, 1'b1})
            $display("FAIL stur_mid_reset: state=%0d memwrite=%b irwrite=%b want 0/0/1", state, memwrite, irwrite);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur();
        test_cbz();
        test_movz();
        test_illegal();
        test_stur_timeout();
        test_stur_late_ready();
        test_stur_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
